// File: rtl/mmio_port_responder_if.sv
// Processor data-memory bus as seen by the MMIO responder: address, store data,
// strobes, and the combinational load data / window-hit returned by the responder.
interface mmio_port_responder_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Hit;

  modport master (
    output Address, WriteData, MemWrite, MemRead,
    input  ReadData, Hit
  );

  modport slave (
    input  Address, WriteData, MemWrite, MemRead,
    output ReadData, Hit
  );
endinterface

// File: rtl/mmio_port_responder.sv
// MMIO responder: 32-byte word window with PORT_OUT, synchronized PORT_IN, STATUS and a
// byte TX FIFO drained as a valid/ready stream. Define MMIO_PORT_IRQ_EN for CTRL + irq.
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0400,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  mmio_port_responder_if.slave  bus,
  input  logic [7:0]            PortIn,
  output logic [31:0]           PortOut,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
`ifdef MMIO_PORT_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [4:0] OFF_PORT_OUT = 5'h00;
  localparam logic [4:0] OFF_PORT_IN  = 5'h04;
  localparam logic [4:0] OFF_STATUS   = 5'h08;
  localparam logic [4:0] OFF_TX_DATA  = 5'h0C;
`ifdef MMIO_PORT_IRQ_EN
  localparam logic [4:0] OFF_CTRL     = 5'h10;
`endif

  logic [4:0]    offset;
  logic          aligned;
  logic          wrEn;
  logic [31:0]   rdData;

  logic [7:0]    s1, s2, prev;
  logic          inChanged;
  logic          overflow;

  logic [7:0]    fifoMem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr, count;
  logic          full, empty;
  logic          push, pushOk, pop;
  logic          changeSet, changeClr, ovfClr;

`ifdef MMIO_PORT_IRQ_EN
  logic [2:0]    ctrl;
`endif

  assign offset  = bus.Address[4:0];
  assign aligned = (bus.Address[1:0] == 2'b00);
  assign bus.Hit = (bus.Address[31:5] == BASE_ADDR[31:5]);
  assign wrEn    = bus.Hit && bus.MemWrite && aligned;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign count = wptr - rptr;
  assign full  = (count == PW'(FIFO_DEPTH));
  assign empty = (count == '0);

  assign push   = wrEn && (offset == OFF_TX_DATA);
  assign pushOk = push && !full;
  assign pop    = tx_valid && tx_ready;

  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : fifoMem[rptr[AW-1:0]];

  assign changeSet = (s2 != prev);
  assign changeClr = wrEn && (offset == OFF_STATUS) && bus.WriteData[0];
  assign ovfClr    = wrEn && (offset == OFF_STATUS) && bus.WriteData[3];

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it
  // holding its old value and a latch is never inferred.
  always_comb begin
    rdData = 32'h0;
    if (bus.Hit && bus.MemRead && aligned) begin
      case (offset)
        OFF_PORT_OUT: rdData = PortOut;
        OFF_PORT_IN:  rdData = {24'h0, s2};
        OFF_STATUS:   rdData = {28'h0, overflow, empty, full, inChanged};
`ifdef MMIO_PORT_IRQ_EN
        OFF_CTRL:     rdData = {29'h0, ctrl};
`endif
        default:      rdData = 32'h0;
      endcase
    end
  end

  assign bus.ReadData = rdData;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge
  // values; this is what makes s1 -> s2 -> prev a real shift chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PortOut   <= 32'h0;
      s1        <= 8'h00;
      s2        <= 8'h00;
      prev      <= 8'h00;
      inChanged <= 1'b0;
      overflow  <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
    end else begin
      s1   <= PortIn;
      s2   <= s1;
      prev <= s2;

      if (wrEn && (offset == OFF_PORT_OUT)) PortOut <= bus.WriteData;

      // Hardware set wins over a same-cycle software clear.
      inChanged <= changeSet || (inChanged && !changeClr);
      overflow  <= (push && full) || (overflow && !ovfClr);

      if (pushOk) wptr <= wptr + PW'(1);
      if (pop)    rptr <= rptr + PW'(1);
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; the pointers define which entries are
  // live, and resetting an array costs a reset net per bit for no behavioural gain.
  always_ff @(posedge clk) begin
    if (pushOk) fifoMem[wptr[AW-1:0]] <= bus.WriteData[7:0];
  end

`ifdef MMIO_PORT_IRQ_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl <= 3'b000;
      irq  <= 1'b0;
    end else begin
      if (wrEn && (offset == OFF_CTRL)) ctrl <= bus.WriteData[2:0];
      irq <= (inChanged && ctrl[0]) || (empty && ctrl[1]) || (overflow && ctrl[2]);
    end
  end
`endif

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed bench for mmio_port_responder: register map, PortIn sync/sticky detect,
// TX FIFO full/overflow/ordering, asynchronous reset, and (MMIO_PORT_IRQ_EN) irq.
module tb_mmio_port_responder;

  localparam logic [31:0] BASE       = 32'h1001_0400;
  localparam logic [31:0] A_PORT_OUT = BASE + 32'h00;
  localparam logic [31:0] A_PORT_IN  = BASE + 32'h04;
  localparam logic [31:0] A_STATUS   = BASE + 32'h08;
  localparam logic [31:0] A_TX_DATA  = BASE + 32'h0C;
  localparam logic [31:0] A_CTRL     = BASE + 32'h10;

  logic        clk;
  logic        reset;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
`ifdef MMIO_PORT_IRQ_EN
  logic        irq;
`endif

  int nChecks = 0;
  int nFails  = 0;

  mmio_port_responder_if bus ();

  mmio_port_responder #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .PortIn   (PortIn),
    .PortOut  (PortOut),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
`ifdef MMIO_PORT_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    bus.Address   = addr;
    bus.WriteData = data;
    bus.MemWrite  = 1'b1;
    tick();
    bus.MemWrite  = 1'b0;
  endtask

  task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
    bus.Address = addr;
    bus.MemRead = 1'b1;
    #1;
    data = bus.ReadData;
    bus.MemRead = 1'b0;
  endtask

  task automatic checkRead(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    busRead(addr, d);
    check(tag, d, exp);
  endtask

  logic [7:0] expBytes [4];

  initial begin
    reset         = 1'b0;
    PortIn        = 8'h00;
    tx_ready      = 1'b0;
    bus.Address   = 32'h0;
    bus.WriteData = 32'h0;
    bus.MemWrite  = 1'b0;
    bus.MemRead   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst PortOut", PortOut, 32'h0);
    check("rst tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst tx_data", {24'h0, tx_data}, 32'h0);
    reset = 1'b1;
    tick();
    checkRead("status after reset", A_STATUS, 32'h4);

    // PORT_OUT store/load, window miss, misaligned access
    busWrite(A_PORT_OUT, 32'h0000_00A5);
    check("PortOut after store", PortOut, 32'h0000_00A5);
    checkRead("load PORT_OUT", A_PORT_OUT, 32'h0000_00A5);
    bus.Address = 32'h1001_0000;
    bus.MemRead = 1'b1;
    #1;
    check("miss Hit", {31'h0, bus.Hit}, 32'h0);
    check("miss ReadData", bus.ReadData, 32'h0);
    bus.MemRead = 1'b0;
    checkRead("misaligned read", BASE + 32'h1, 32'h0);
    busWrite(BASE + 32'h1, 32'hFFFF_FFFF);
    check("misaligned write ignored", PortOut, 32'h0000_00A5);
    checkRead("TX_DATA reads 0", A_TX_DATA, 32'h0);

    // PortIn synchronizer and sticky change flag
    PortIn = 8'h3C;
    tick();
    checkRead("PORT_IN after 1 edge", A_PORT_IN, 32'h0);
    tick();
    checkRead("PORT_IN after 2 edges", A_PORT_IN, 32'h3C);
    checkRead("changed after 2 edges", A_STATUS, 32'h4);
    tick();
    checkRead("changed after 3 edges", A_STATUS, 32'h5);
    busWrite(A_STATUS, 32'h1);
    checkRead("changed cleared", A_STATUS, 32'h4);
    PortIn = 8'h5A;
    tick();
    tick();
    busWrite(A_STATUS, 32'h1);
    checkRead("set beats clear", A_STATUS, 32'h5);
    busWrite(A_STATUS, 32'h1);
    checkRead("changed cleared again", A_STATUS, 32'h4);

    // Fill, overflow, drain
    tx_ready = 1'b0;
    busWrite(A_TX_DATA, 32'h11);
    check("valid after push", {31'h0, tx_valid}, 32'h1);
    check("head after push", {24'h0, tx_data}, 32'h11);
    busWrite(A_TX_DATA, 32'h22);
    busWrite(A_TX_DATA, 32'h33);
    busWrite(A_TX_DATA, 32'h44);
    checkRead("status full", A_STATUS, 32'h2);
    busWrite(A_TX_DATA, 32'h55);
    checkRead("status overflow", A_STATUS, 32'hA);
    expBytes[0] = 8'h11;
    expBytes[1] = 8'h22;
    expBytes[2] = 8'h33;
    expBytes[3] = 8'h44;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain valid %0d", i), {31'h0, tx_valid}, 32'h1);
      check($sformatf("drain data %0d", i), {24'h0, tx_data}, {24'h0, expBytes[i]});
      tick();
    end
    check("drained valid", {31'h0, tx_valid}, 32'h0);
    checkRead("status drained", A_STATUS, 32'hC);
    busWrite(A_STATUS, 32'h8);
    checkRead("overflow cleared", A_STATUS, 32'h4);

    // Push and pop together at count 2
    tx_ready = 1'b0;
    busWrite(A_TX_DATA, 32'h77);
    busWrite(A_TX_DATA, 32'h88);
    tx_ready = 1'b1;
    busWrite(A_TX_DATA, 32'h66);
    tx_ready = 1'b0;
    checkRead("status count 2", A_STATUS, 32'h0);
    check("head after push+pop", {24'h0, tx_data}, 32'h88);
    tx_ready = 1'b1;
    tick();
    check("order second", {24'h0, tx_data}, 32'h66);
    tick();
    check("empty after pair", {31'h0, tx_valid}, 32'h0);

    // Push and pop together while full: push dropped, three remain
    tx_ready = 1'b0;
    busWrite(A_TX_DATA, 32'hA1);
    busWrite(A_TX_DATA, 32'hA2);
    busWrite(A_TX_DATA, 32'hA3);
    busWrite(A_TX_DATA, 32'hA4);
    tx_ready = 1'b1;
    busWrite(A_TX_DATA, 32'hA5);
    tx_ready = 1'b0;
    checkRead("full push+pop status", A_STATUS, 32'h8);
    check("full push+pop head", {24'h0, tx_data}, 32'hA2);
    busWrite(A_STATUS, 32'h8);
    checkRead("three queued", A_STATUS, 32'h0);

    // Asynchronous reset mid-stream
    PortIn = 8'h00;
    tx_ready = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    check("async rst tx_valid", {31'h0, tx_valid}, 32'h0);
    check("async rst PortOut", PortOut, 32'h0);
    check("async rst tx_data", {24'h0, tx_data}, 32'h0);
    tx_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checkRead("status after mid reset", A_STATUS, 32'h4);

`ifdef MMIO_PORT_IRQ_EN
    busWrite(A_CTRL, 32'h2);
    checkRead("CTRL readback", A_CTRL, 32'h2);
    check("irq not yet", {31'h0, irq}, 32'h0);
    tick();
    check("irq on empty", {31'h0, irq}, 32'h1);
    busWrite(A_TX_DATA, 32'h99);
    check("irq still high at push edge", {31'h0, irq}, 32'h1);
    tick();
    check("irq drops when non-empty", {31'h0, irq}, 32'h0);
`else
    busWrite(A_CTRL, 32'hFFFF_FFFF);
    checkRead("CTRL absent reads 0", A_CTRL, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
    $finish;
  end

endmodule
